// File: rtl/quarterwave_sintable_pkg.sv
// Shared constants and elaboration-time helpers for the quarter-wave sine generator.
// Holds the pipeline latency, the quadrant encoding and the table generator.
package quarterwave_sintable_pkg;

  localparam int LATENCY = 3;

  typedef enum logic [1:0] {
    QUAD_0 = 2'd0,
    QUAD_1 = 2'd1,
    QUAD_2 = 2'd2,
    QUAD_3 = 2'd3
  } quadrant_e;

  localparam real PI = 3.14159265358979323846;

  // Quadrants 1 and 3 walk the quarter table backwards.
  function automatic logic quad_mirrored(input quadrant_e q);
    return (q == QUAD_1) || (q == QUAD_3);
  endfunction

  function automatic logic quad_negative(input quadrant_e q);
    return (q == QUAD_2) || (q == QUAD_3);
  endfunction

  // Every table angle lies in (0, pi/2), where this series converges to full double precision.
  function automatic real sin_taylor(input real x);
    real term;
    real sum;
    term = x;
    sum  = x;
    for (int n = 1; n < 14; n++) begin
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    return sum;
  endfunction

  function automatic int table_entry(input int pw, input int ow, input int k);
    real amp;
    real ang;
    amp = real'((1 << (ow - 1)) - 1);
    ang = 2.0 * PI * (real'(k) + 0.5) / real'(1 << pw);
    return $rtoi(amp * sin_taylor(ang) + 0.5);
  endfunction

endpackage

// File: rtl/quarterwave_rom.sv
// Synchronous-read quarter-wave sine ROM with one cycle of read latency.
// Contents are computed at elaboration from PW and OW; the storage has no reset.
module quarterwave_rom
  import quarterwave_sintable_pkg::*;
#(
  parameter int PW = 10,
  parameter int OW = 16
) (
  input  logic          i_clk,
  input  logic [PW-3:0] i_addr,
  output logic [OW-2:0] o_data
);

  localparam int DEPTH = 1 << (PW - 2);

  logic [OW-2:0] table_mem [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    localparam logic [OW-2:0] ENTRY = (OW-1)'(table_entry(PW, OW, gi));
    assign table_mem[gi] = ENTRY;
  end

  always_ff @(posedge i_clk) begin
    o_data <= table_mem[i_addr];
  end

endmodule

// File: rtl/quarterwave_sintable.sv
// Three-stage pipelined sine lookup: quadrant decode, quarter-table read, sign apply.
// Accepts one phase per clock; results appear exactly LATENCY cycles later with their tag.
module quarterwave_sintable
  import quarterwave_sintable_pkg::*;
#(
  parameter int PW = 10,
  parameter int OW = 16,
  parameter int AW = 1
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_valid,
  input  logic [PW-1:0] i_phase,
  input  logic [AW-1:0] i_aux,
  output logic          o_valid,
  output logic [OW-1:0] o_sample,
  output logic [AW-1:0] o_aux
);

  quadrant_e     quad;
  logic [PW-3:0] index_next;

  logic [PW-3:0] s1_index_reg;
  logic          s1_neg_reg;
  logic          s1_valid_reg;
  logic [AW-1:0] s1_aux_reg;

  logic [OW-2:0] s2_mag;
  logic          s2_neg_reg;
  logic          s2_valid_reg;
  logic [AW-1:0] s2_aux_reg;

  logic [OW-1:0] mag_ext;
  logic [OW-1:0] sample_next;

  assign quad       = quadrant_e'(i_phase[PW-1:PW-2]);
  assign index_next = quad_mirrored(quad) ? ~i_phase[PW-3:0] : i_phase[PW-3:0];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      s1_index_reg <= '0;
      s1_neg_reg   <= 1'b0;
      s1_valid_reg <= 1'b0;
      s1_aux_reg   <= '0;
    end else begin
      s1_index_reg <= index_next;
      s1_neg_reg   <= quad_negative(quad);
      s1_valid_reg <= i_valid;
      s1_aux_reg   <= i_aux;
    end
  end

  quarterwave_rom #(
    .PW (PW),
    .OW (OW)
  ) u_rom (
    .i_clk  (i_clk),
    .i_addr (s1_index_reg),
    .o_data (s2_mag)
  );

  // Sideband travels alongside the ROM read so it lines up with s2_mag.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      s2_neg_reg   <= 1'b0;
      s2_valid_reg <= 1'b0;
      s2_aux_reg   <= '0;
    end else begin
      s2_neg_reg   <= s1_neg_reg;
      s2_valid_reg <= s1_valid_reg;
      s2_aux_reg   <= s1_aux_reg;
    end
  end

  // Table entries are never zero and never exceed 2^(OW-1)-1, so negation cannot overflow.
  assign mag_ext     = {1'b0, s2_mag};
  assign sample_next = s2_neg_reg ? -mag_ext : mag_ext;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_valid  <= 1'b0;
      o_sample <= '0;
      o_aux    <= '0;
    end else begin
      o_valid <= s2_valid_reg;
      if (s2_valid_reg) begin
        o_sample <= sample_next;
        o_aux    <= s2_aux_reg;
      end
    end
  end

endmodule

// File: tb/tb_quarterwave_sintable.sv
// Directed bench for quarterwave_sintable: PW=10/OW=16 main instance plus a PW=4/OW=8 instance.
// Drives inputs on the falling edge and samples outputs on the falling edge.
module tb_quarterwave_sintable;
  import quarterwave_sintable_pkg::*;

  localparam int  PW  = 10;
  localparam int  OW  = 16;
  localparam int  AW  = 1;
  localparam int  SPW = 4;
  localparam int  SOW = 8;
  localparam real TWO_PI = 6.283185307179586;

  typedef struct {
    int phase;
    int aux;
    int exp_sample;
  } vec_t;

  logic                 i_clk   = 1'b0;
  logic                 i_reset = 1'b0;
  logic                 i_valid = 1'b0;
  logic [PW-1:0]        i_phase = '0;
  logic [AW-1:0]        i_aux   = '0;
  logic                 o_valid;
  logic signed [OW-1:0] o_sample;
  logic [AW-1:0]        o_aux;

  logic                  s_valid = 1'b0;
  logic [SPW-1:0]        s_phase = '0;
  logic [AW-1:0]         s_aux   = '0;
  logic                  so_valid;
  logic signed [SOW-1:0] so_sample;
  logic [AW-1:0]         so_aux;

  int checks   = 0;
  int failures = 0;
  int hold_s   = 0;
  int hold_a   = 0;
  int sv[$];
  int sp[$];
  int sa[$];
  int es[$];
  int got_s[$];

  always #5 i_clk = ~i_clk;

  quarterwave_sintable #(.PW(PW), .OW(OW), .AW(AW)) dut (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_valid  (i_valid),
    .i_phase  (i_phase),
    .i_aux    (i_aux),
    .o_valid  (o_valid),
    .o_sample (o_sample),
    .o_aux    (o_aux)
  );

  quarterwave_sintable #(.PW(SPW), .OW(SOW), .AW(AW)) dut_small (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_valid  (s_valid),
    .i_phase  (s_phase),
    .i_aux    (s_aux),
    .o_valid  (so_valid),
    .o_sample (so_sample),
    .o_aux    (so_aux)
  );

  task automatic check(input string name, input longint got, input longint exp, input int tol);
    longint diff;
    checks++;
    diff = got - exp;
    if (diff < 0) diff = -diff;
    if (diff > longint'(tol)) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", name, got, exp, tol);
    end
  endtask

  // One isolated request: checks exact latency, the result, then that it holds afterwards.
  task automatic single(input vec_t v);
    i_valid = 1'b1;
    i_phase = PW'(v.phase);
    i_aux   = AW'(v.aux);
    @(posedge i_clk);
    @(negedge i_clk);
    i_valid = 1'b0;
    check($sformatf("single p=%0d lat1 o_valid", v.phase), longint'(o_valid), 0, 0);
    @(negedge i_clk);
    check($sformatf("single p=%0d lat2 o_valid", v.phase), longint'(o_valid), 0, 0);
    @(negedge i_clk);
    check($sformatf("single p=%0d lat3 o_valid", v.phase), longint'(o_valid), 1, 0);
    check($sformatf("single p=%0d o_sample", v.phase), longint'(o_sample), v.exp_sample, 0);
    check($sformatf("single p=%0d o_aux", v.phase), longint'(o_aux), v.aux, 0);
    $display("txn single phase=%0d aux=%0d -> sample=%0d aux=%0d (expect %0d)",
             v.phase, v.aux, o_sample, o_aux, v.exp_sample);
    hold_s = v.exp_sample;
    hold_a = v.aux;
    @(negedge i_clk);
    check($sformatf("single p=%0d after o_valid", v.phase), longint'(o_valid), 0, 0);
    check($sformatf("single p=%0d hold o_sample", v.phase), longint'(o_sample), hold_s, 0);
    check($sformatf("single p=%0d hold o_aux", v.phase), longint'(o_aux), hold_a, 0);
  endtask

  // Streams sv/sp/sa one entry per cycle and checks every output cycle against es.
  task automatic run_stream(input string name, input int tol);
    int n;
    int j;
    int ev;
    n = sv.size();
    for (int k = 0; k <= n + LATENCY; k++) begin
      j = k - LATENCY;
      if (j >= 0) begin
        ev = (j < n) ? sv[j] : 0;
        check($sformatf("%s[%0d] o_valid", name, j), longint'(o_valid), ev, 0);
        if (ev != 0) begin
          hold_s = es[j];
          hold_a = sa[j];
          got_s.push_back(int'(o_sample));
        end
        check($sformatf("%s[%0d] o_sample", name, j), longint'(o_sample), hold_s, tol);
        check($sformatf("%s[%0d] o_aux", name, j), longint'(o_aux), hold_a, 0);
        if (tol == 0)
          $display("txn %s[%0d] valid=%0d sample=%0d aux=%0d", name, j, o_valid, o_sample, o_aux);
      end
      if (k < n) begin
        i_valid = (sv[k] != 0);
        i_phase = PW'(sp[k]);
        i_aux   = AW'(sa[k]);
      end else begin
        i_valid = 1'b0;
      end
      @(negedge i_clk);
    end
  endtask

  initial begin
    vec_t vecs[10];
    int   stab[16];
    int   j;
    real  m;

    vecs = '{'{0, 1, 101}, '{256, 0, 32767}, '{512, 1, -101}, '{768, 0, -32767},
             '{1023, 1, -101}, '{255, 0, 32767}, '{511, 1, 101}, '{767, 0, -32767},
             '{128, 1, 23241}, '{640, 0, -23241}};
    stab = '{25, 71, 106, 125, 125, 106, 71, 25, -25, -71, -106, -125, -125, -106, -71, -25};

    #1 i_reset = 1'b1;
    #1;
    check("reset o_valid", longint'(o_valid), 0, 0);
    check("reset o_sample", longint'(o_sample), 0, 0);
    check("reset o_aux", longint'(o_aux), 0, 0);
    check("reset small o_valid", longint'(so_valid), 0, 0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b0;
    foreach (vecs[i]) single(vecs[i]);

    sv = '{1, 1, 1}; sp = '{256, 512, 768}; sa = '{0, 1, 0}; es = '{32767, -101, -32767};
    run_stream("b2b", 0);

    sv = '{1, 0, 1, 1, 0}; sp = '{0, 256, 512, 768, 256}; sa = '{1, 0, 0, 1, 1};
    es = '{101, 0, -101, -32767, 0};
    run_stream("pattern", 0);

    sv = '{1, 1}; sp = '{1023, 0}; sa = '{0, 1}; es = '{-101, 101};
    run_stream("wrap", 0);

    sv.delete(); sp.delete(); sa.delete(); es.delete(); got_s.delete();
    for (int p = 0; p < 1024; p++) begin
      m = 32767.0 * $sin(TWO_PI * (real'(p) + 0.5) / 1024.0);
      sv.push_back(1);
      sp.push_back(p);
      sa.push_back(p % 2);
      es.push_back($rtoi(m >= 0.0 ? m + 0.5 : m - 0.5));
    end
    run_stream("sweep", 1);
    check("sweep result count", got_s.size(), 1024, 0);
    if (got_s.size() == 1024) begin
      for (int p = 0; p < 512; p++)
        check($sformatf("sweep antisym p=%0d", p), got_s[p], -got_s[p + 512], 0);
    end
    $display("txn sweep done results=%0d", got_s.size());

    for (int k = 0; k <= 16 + LATENCY; k++) begin
      j = k - LATENCY;
      if (j >= 0) begin
        check($sformatf("small[%0d] o_valid", j), longint'(so_valid), (j < 16) ? 1 : 0, 0);
        check($sformatf("small[%0d] o_sample", j), longint'(so_sample), stab[(j < 16) ? j : 15], 0);
        check($sformatf("small[%0d] o_aux", j), longint'(so_aux), ((j < 16) ? j : 15) % 2, 0);
        $display("txn small[%0d] valid=%0d sample=%0d aux=%0d", j, so_valid, so_sample, so_aux);
      end
      if (k < 16) begin
        s_valid = 1'b1;
        s_phase = SPW'(k);
        s_aux   = AW'(k % 2);
      end else begin
        s_valid = 1'b0;
      end
      @(negedge i_clk);
    end

    // Two requests in flight, reset lands asynchronously just after the first one emerges.
    i_valid = 1'b1; i_phase = PW'(256); i_aux = 1'b1;
    @(negedge i_clk);
    i_phase = PW'(768); i_aux = 1'b0;
    @(negedge i_clk);
    i_valid = 1'b0;
    @(negedge i_clk);
    check("prereset o_valid", longint'(o_valid), 1, 0);
    check("prereset o_sample", longint'(o_sample), 32767, 0);
    #2 i_reset = 1'b1;
    #1;
    check("async reset o_valid", longint'(o_valid), 0, 0);
    check("async reset o_sample", longint'(o_sample), 0, 0);
    check("async reset o_aux", longint'(o_aux), 0, 0);
    check("async reset small o_sample", longint'(so_sample), 0, 0);
    $display("txn reset asserted valid=%0d sample=%0d aux=%0d", o_valid, o_sample, o_aux);
    @(negedge i_clk);
    i_reset = 1'b0;
    single('{384, 1, 23099});
    for (int k = 0; k < 2; k++) begin
      @(negedge i_clk);
      check($sformatf("post-reset idle %0d o_valid", k), longint'(o_valid), 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
